fwd_ctrl: RTL

Forwarding and hazard controller for the five-stage pipeline. It tracks the destination registers of the instructions in EX and MEM, and drives the `fwd_A`/`fwd_B` select codes that the execute stage uses to pick between register-file data, EX/MEM data and MEM/WB data. It detects load-use hazards, stalls decode for one cycle and injects a bubble. It also keeps a saturating count of hazard stall cycles.

---
 rtl/fwd_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/fwd_ctrl.sv
// Purpose: forwarding-select and load-use hazard control for the 5-stage pipe (optional feature macro: FWD_BYPASS_EN).
// Latency: fwd_A/fwd_B registered (computed in decode, visible while the instruction sits in EX); stall_id combinational.
// Backpressure: mem_stall freezes all state; hazards stall decode and inject an EX bubble, counted in stall_cnt.
module fwd_ctrl #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_use,
    input  logic             id_rt_use,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    input  logic             mem_stall,
    output logic [1:0]       fwd_A,
    output logic [1:0]       fwd_B,
    output logic             stall_id,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err
);

    // Shadow copies of the EX and MEM destination info
    logic             ex_v;
    logic [REG_W-1:0] ex_rd;
    logic             ex_wr;
    logic             ex_ld;
    logic             mem_v;
    logic [REG_W-1:0] mem_rd;
    logic             mem_wr;

    logic             rs_ex, rt_ex, rs_mem, rt_mem;
    logic             hazard;
    logic [1:0]       sel_a, sel_b;

    assign err = 1'b0;

    // Source/slot matches; r0 is treated like any other register
    always_comb begin
        rs_ex  = id_valid & id_rs_use & ex_v  & ex_wr  & (ex_rd  == id_rs);
        rt_ex  = id_valid & id_rt_use & ex_v  & ex_wr  & (ex_rd  == id_rt);
        rs_mem = id_valid & id_rs_use & mem_v & mem_wr & (mem_rd == id_rs);
        rt_mem = id_valid & id_rt_use & mem_v & mem_wr & (mem_rd == id_rt);
    end

`ifdef FWD_BYPASS_EN
    // Full bypass: only a load in EX cannot be forwarded in time; EX slot wins over MEM
    always_comb begin
        hazard = (rs_ex | rt_ex) & ex_ld;
        sel_a  = rs_ex ? 2'b10 : (rs_mem ? 2'b01 : 2'b00);
        sel_b  = rt_ex ? 2'b10 : (rt_mem ? 2'b01 : 2'b00);
    end
`else
    // No bypass: hold decode until the producer has left MEM (WB writes bypass in the regfile)
    logic unused_ld;
    assign unused_ld = ex_ld;

    always_comb begin
        hazard = rs_ex | rt_ex | rs_mem | rt_mem;
        sel_a  = 2'b00;
        sel_b  = 2'b00;
    end
`endif

    // A taken branch squashes the decode instruction, so it cannot cause a stall
    assign stall_id = hazard & ~flush;

    // Pipeline shadow advance, bubble injection and stall counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_v      <= 1'b0;
            ex_rd     <= '0;
            ex_wr     <= 1'b0;
            ex_ld     <= 1'b0;
            mem_v     <= 1'b0;
            mem_rd    <= '0;
            mem_wr    <= 1'b0;
            fwd_A     <= 2'b00;
            fwd_B     <= 2'b00;
            stall_cnt <= '0;
        end else if (!mem_stall) begin
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            mem_wr <= ex_wr;
            if (flush || stall_id) begin
                ex_v  <= 1'b0;
                ex_wr <= 1'b0;
                ex_ld <= 1'b0;
                fwd_A <= 2'b00;
                fwd_B <= 2'b00;
                if (!flush && (stall_cnt != '1)) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end else begin
                ex_v  <= id_valid;
                ex_rd <= id_rd;
                ex_wr <= id_regwrite;
                ex_ld <= id_memread;
                fwd_A <= sel_a;
                fwd_B <= sel_b;
            end
        end
    end

endmodule
